// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer for the 8x8 matmul unit.
// Walks output/reduction tiles and drives activate, addresses and edge masks.
module matmul_tile_sequencer #(
  parameter int MAT_MUL_SIZE      = 8,
  parameter int LOG2_MAT_MUL_SIZE = 3,
  parameter int DIM_WIDTH         = 8,
  parameter int AWIDTH            = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DIM_WIDTH-1:0]    cmd_m,
  input  logic [DIM_WIDTH-1:0]    cmd_n,
  input  logic [DIM_WIDTH-1:0]    cmd_k,
  input  logic [AWIDTH-1:0]       cmd_a_base,
  input  logic [AWIDTH-1:0]       cmd_b_base,
  input  logic [AWIDTH-1:0]       cmd_c_base,
  input  logic                    abort,
  output logic                    mm_activate,
  input  logic                    mm_busy,
  output logic [AWIDTH-1:0]       a_addr,
  output logic [AWIDTH-1:0]       b_addr,
  output logic [AWIDTH-1:0]       c_addr,
  output logic                    acc_clear,
  output logic                    c_we,
  output logic [MAT_MUL_SIZE-1:0] mask_a_rows,
  output logic [MAT_MUL_SIZE-1:0] mask_a_cols,
  output logic [MAT_MUL_SIZE-1:0] mask_b_rows,
  output logic [MAT_MUL_SIZE-1:0] mask_b_cols,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CW = DIM_WIDTH - LOG2_MAT_MUL_SIZE + 1;
  localparam int RW = LOG2_MAT_MUL_SIZE;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_HI, WAIT_LO, WRITE, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     mt, nt, kt;
  logic [CW-1:0]     mi, ni, ki;
  logic [RW-1:0]     rm, rn, rk;
  logic [AWIDTH-1:0] b_base, a_row, b_col;
  logic [AWIDTH-1:0] a_q, b_q, c_q;

  logic accept, zero_dim;
  logic last_mi, last_ni, last_ki;
  logic step_k, wr;
  logic [AWIDTH-1:0] nt_a, kt_a;

  function automatic logic [CW-1:0] tiles(
    input logic [DIM_WIDTH-1:0] d
  );
    logic [DIM_WIDTH:0] s;
    s = {1'b0, d} + (DIM_WIDTH+1)'(MAT_MUL_SIZE - 1);
    return s[DIM_WIDTH:RW];
  endfunction

  function automatic logic [MAT_MUL_SIZE-1:0] edge_mask(
    input logic          last,
    input logic [RW-1:0] r
  );
    if (last && r != '0)
      return (MAT_MUL_SIZE'(1) << r) - MAT_MUL_SIZE'(1);
    return '1;
  endfunction

  assign cmd_ready = (state == IDLE) && !mm_busy;
  assign accept    = cmd_valid && cmd_ready;
  assign zero_dim  = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0);

  assign last_mi = (mi == mt - CW'(1));
  assign last_ni = (ni == nt - CW'(1));
  assign last_ki = (ki == kt - CW'(1));

  assign nt_a = {{(AWIDTH-CW){1'b0}}, nt};
  assign kt_a = {{(AWIDTH-CW){1'b0}}, kt};

  assign step_k = (state == WAIT_LO) && !mm_busy
                  && !last_ki && !abort;
  assign wr     = (state == WRITE) && !abort;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && !zero_dim) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT_HI;
      WAIT_HI: if (mm_busy) state_nx = WAIT_LO;
      WAIT_LO: if (!mm_busy) state_nx = last_ki ? WRITE : ISSUE;
      WRITE:   state_nx = (last_mi && last_ni) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mt <= '0; nt <= '0; kt <= '0;
      mi <= '0; ni <= '0; ki <= '0;
      rm <= '0; rn <= '0; rk <= '0;
      b_base <= '0; a_row <= '0; b_col <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0;
      err <= 1'b0;
    end else begin
      err <= accept && zero_dim;
      if (accept) begin
        mt <= tiles(cmd_m);
        nt <= tiles(cmd_n);
        kt <= tiles(cmd_k);
        rm <= cmd_m[RW-1:0];
        rn <= cmd_n[RW-1:0];
        rk <= cmd_k[RW-1:0];
        mi <= '0; ni <= '0; ki <= '0;
        a_q    <= cmd_a_base;
        a_row  <= cmd_a_base;
        b_base <= cmd_b_base;
        b_col  <= cmd_b_base;
        b_q    <= cmd_b_base;
        c_q    <= cmd_c_base;
      end else if (step_k) begin
        ki  <= ki + CW'(1);
        a_q <= a_q + AWIDTH'(1);
        b_q <= b_q + nt_a;
      end else if (wr) begin
        ki  <= '0;
        c_q <= c_q + AWIDTH'(1);
        if (last_ni) begin
          // next output row: A restarts one row of K tiles further on
          ni    <= '0;
          mi    <= mi + CW'(1);
          a_row <= a_row + kt_a;
          a_q   <= a_row + kt_a;
          b_col <= b_base;
          b_q   <= b_base;
        end else begin
          ni    <= ni + CW'(1);
          a_q   <= a_row;
          b_col <= b_col + AWIDTH'(1);
          b_q   <= b_col + AWIDTH'(1);
        end
      end
    end
  end

  assign busy        = (state != IDLE);
  assign mm_activate = (state == ISSUE);
  assign acc_clear   = (state == ISSUE) && (ki == '0);
  assign c_we        = (state == WRITE);
  assign done        = (state == DONE);

  assign a_addr = a_q;
  assign b_addr = b_q;
  assign c_addr = c_q;

  assign mask_a_rows = busy ? edge_mask(last_mi, rm) : '0;
  assign mask_a_cols = busy ? edge_mask(last_ki, rk) : '0;
  assign mask_b_rows = busy ? edge_mask(last_ki, rk) : '0;
  assign mask_b_cols = busy ? edge_mask(last_ni, rn) : '0;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer with a simple
// fixed-latency matmul unit model.
module tb_matmul_tile_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_m = '0, cmd_n = '0, cmd_k = '0;
  logic [9:0] cmd_a_base = '0, cmd_b_base = '0, cmd_c_base = '0;
  logic       abort = 1'b0;
  logic       mm_activate, mm_busy;
  logic [9:0] a_addr, b_addr, c_addr;
  logic       acc_clear, c_we, busy, done, err;
  logic [7:0] mask_a_rows, mask_a_cols, mask_b_rows, mask_b_cols;

  matmul_tile_sequencer dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .cmd_c_base(cmd_c_base),
    .abort(abort),
    .mm_activate(mm_activate), .mm_busy(mm_busy),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .acc_clear(acc_clear), .c_we(c_we),
    .mask_a_rows(mask_a_rows), .mask_a_cols(mask_a_cols),
    .mask_b_rows(mask_b_rows), .mask_b_cols(mask_b_cols),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 3;
  int cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // matmul unit: busy for lat cycles starting the cycle after activate
  always @(posedge clk) begin
    if (mm_activate)  cnt <= lat;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  assign mm_busy = (cnt != 0);

  int          n_act, n_cwe, n_done, n_err;
  int          done_cyc, err_cyc, acc_cyc;
  logic [9:0]  la [16];
  logic [9:0]  lb [16];
  logic        lclr [16];
  logic [31:0] lmask [16];
  logic [9:0]  lc [8];

  always @(negedge clk) begin
    if (mm_activate) begin
      if (n_act < 16) begin
        la[n_act]    <= a_addr;
        lb[n_act]    <= b_addr;
        lclr[n_act]  <= acc_clear;
        lmask[n_act] <= {mask_a_rows, mask_a_cols,
                         mask_b_rows, mask_b_cols};
      end
      n_act <= n_act + 1;
    end
    if (c_we) begin
      if (n_cwe < 8) lc[n_cwe] <= c_addr;
      n_cwe <= n_cwe + 1;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    #1;
    n_act = 0; n_cwe = 0; n_done = 0; n_err = 0;
    done_cyc = 0; err_cyc = 0;
  endtask

  task automatic send(input logic [7:0] m, n, k,
                      input logic [9:0] ab, bb, cb);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("ready_wait", 32'(i < 200), 32'd1);
    cmd_m = m; cmd_n = n; cmd_k = k;
    cmd_a_base = ab; cmd_b_base = bb; cmd_c_base = cb;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (n_done > 0 || n_err > 0) break;
    end
    chk("end_wait", 32'(i < max), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int i;
    int cwe_snap;
    logic held;
    logic [7:0] ar, ac;

    // reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act", 32'(mm_activate), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cwe", 32'(c_we), 0);
    chk("rst_clr", 32'(acc_clear), 0);
    chk("rst_addr", {2'b0, a_addr, b_addr, c_addr}, 0);
    chk("rst_mask", {mask_a_rows, mask_a_cols,
                     mask_b_rows, mask_b_cols}, 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    resetn = 1'b1;

    // single tile
    lat = 29;
    clear_log();
    send(8, 8, 8, 0, 0, 0);
    wait_end(100);
    chk("t1_acts", n_act, 1);
    chk("t1_clr", 32'(lclr[0]), 1);
    chk("t1_mask", lmask[0], 32'hFFFF_FFFF);
    chk("t1_cwe", n_cwe, 1);
    chk("t1_caddr", 32'(lc[0]), 0);
    chk("t1_done_n", n_done, 1);
    chk("t1_lat", done_cyc - acc_cyc, 32);

    // ragged edges
    lat = 3;
    clear_log();
    send(12, 5, 20, 10'h10, 10'h40, 10'h80);
    wait_end(200);
    chk("t2_acts", n_act, 6);
    for (int j = 0; j < 6; j++) begin
      ar = (j >= 3) ? 8'h0F : 8'hFF;
      ac = (j % 3 == 2) ? 8'h0F : 8'hFF;
      chk($sformatf("t2_a%0d", j), 32'(la[j]), 32'(10'h10 + j));
      chk($sformatf("t2_b%0d", j), 32'(lb[j]), 32'(10'h40 + j % 3));
      chk($sformatf("t2_clr%0d", j), 32'(lclr[j]),
          32'(j % 3 == 0));
      chk($sformatf("t2_m%0d", j), lmask[j], {ar, ac, ac, 8'h1F});
    end
    chk("t2_cwe", n_cwe, 2);
    chk("t2_c0", 32'(lc[0]), 32'h80);
    chk("t2_c1", 32'(lc[1]), 32'h81);
    chk("t2_done", n_done, 1);

    // zero dimension
    clear_log();
    send(8, 8, 0, 0, 0, 0);
    wait_end(20);
    chk("t3_err_n", n_err, 1);
    chk("t3_err_lat", err_cyc - acc_cyc, 0);
    chk("t3_acts", n_act, 0);
    chk("t3_done", n_done, 0);

    // abort in WAIT_LO of the third tile
    lat = 10;
    clear_log();
    send(16, 16, 16, 0, 0, 0);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_act >= 3) break;
    end
    chk("t4_reach", 32'(i < 200), 1);
    @(negedge clk);
    @(negedge clk);
    cwe_snap = n_cwe;
    chk("t4_busy_pre", 32'(mm_busy), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t4_idle", 32'(busy), 0);
    chk("t4_ready_lo", 32'(cmd_ready), 0);
    held = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mm_busy) break;
      if (cmd_ready) held = 1'b0;
    end
    chk("t4_drain", 32'(i < 50), 1);
    chk("t4_held", 32'(held), 1);
    chk("t4_ready_hi", 32'(cmd_ready), 1);
    repeat (5) @(negedge clk);
    #1;
    chk("t4_acts", n_act, 3);
    chk("t4_cwe_after", n_cwe - cwe_snap, 0);
    chk("t4_done", n_done, 0);

    // address wrap
    lat = 3;
    clear_log();
    send(8, 8, 32, 10'h3FE, 0, 0);
    wait_end(200);
    chk("t5_acts", n_act, 4);
    chk("t5_a0", 32'(la[0]), 32'h3FE);
    chk("t5_a1", 32'(la[1]), 32'h3FF);
    chk("t5_a2", 32'(la[2]), 32'h000);
    chk("t5_a3", 32'(la[3]), 32'h001);
    chk("t5_b3", 32'(lb[3]), 32'h003);
    chk("t5_mask3", lmask[3], 32'hFFFF_FFFF);

    // reset during WAIT_HI
    lat = 10;
    clear_log();
    send(8, 8, 8, 10'h55, 10'h66, 10'h77);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (n_act >= 1) break;
    end
    chk("t6_reach", 32'(i < 50), 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_addr", {2'b0, a_addr, b_addr, c_addr}, 0);
    chk("t6_mask", {mask_a_rows, mask_a_cols,
                    mask_b_rows, mask_b_cols}, 0);
    @(negedge clk);
    resetn = 1'b1;
    lat = 3;
    clear_log();
    send(8, 8, 8, 0, 0, 10'h12);
    wait_end(100);
    chk("t6_acts", n_act, 1);
    chk("t6_cwe", n_cwe, 1);
    chk("t6_caddr", 32'(lc[0]), 32'h12);
    chk("t6_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
